// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM states, nibble constants and a
// parameter sanity helper used by the converter and the display drivers.
package bcd_pkg;

  localparam int unsigned BCD_NIBBLE  = 4;
  localparam int unsigned ADD3_THRESH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when dig decimal digits can hold the largest w-bit operand.
  function automatic bit dig_ok(input int unsigned w, input int unsigned dig);
    longint unsigned p10;
    longint unsigned p2;
    p10 = 64'd1;
    p2  = 64'd1;
    for (int unsigned i = 0; i < dig; i++) p10 = p10 * 64'd10;
    for (int unsigned i = 0; i < w; i++) p2 = p2 << 1;
    return p10 > (p2 - 64'd1);
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the whole {bcd, binary} vector left by one bit.
module bcd_dabble_step import bcd_pkg::*; #(
  parameter int unsigned W   = 8,
  parameter int unsigned DIG = 3
) (
  input  logic [DIG*BCD_NIBBLE+W-1:0] vec,
  output logic [DIG*BCD_NIBBLE+W-1:0] nxt
);

  localparam int unsigned TW = DIG*BCD_NIBBLE + W;

  logic [TW-1:0] adj;

  always_comb begin
    adj = vec;
    for (int unsigned d = 0; d < DIG; d++) begin
      if (adj[W+d*BCD_NIBBLE +: BCD_NIBBLE] >= BCD_NIBBLE'(ADD3_THRESH))
        adj[W+d*BCD_NIBBLE +: BCD_NIBBLE] = adj[W+d*BCD_NIBBLE +: BCD_NIBBLE] + BCD_NIBBLE'(3);
    end
    nxt = adj << 1;
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared binary-to-BCD converter: grants one requester at a time,
// runs W double-dabble steps, then presents the BCD result with a done pulse.
module bcd_conv_arbiter import bcd_pkg::*; #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned DIG   = 3,
  parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*W-1:0]      bin_in,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [DIG*BCD_NIBBLE-1:0] bcd_out
);

  localparam int unsigned BW = DIG*BCD_NIBBLE;
  localparam int unsigned TW = BW + W;
  localparam int unsigned CW = $clog2(W) + 1;

  if (!dig_ok(W, DIG)) begin : g_dig_check
    $error("bcd_conv_arbiter: DIG too small for operand width W");
  end

  state_t          state_q, state_d;
  logic [TW-1:0]   sr_q, sr_d, sr_step;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            busy_d, done_d;
  logic [IDW-1:0]  id_d;
  logic [BW-1:0]   bcd_d;

  logic            hit_hi, hit_lo, found_c;
  logic [IDW-1:0]  win_hi, win_lo, win_c;
  logic [W-1:0]    opnd_c;

  // Round robin: lowest requester at or above ptr, else lowest overall (wrap).
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req[i] && (IDW'(i) >= ptr_q) && !hit_hi) begin
        hit_hi = 1'b1;
        win_hi = IDW'(i);
      end
      if (req[i] && !hit_lo) begin
        hit_lo = 1'b1;
        win_lo = IDW'(i);
      end
    end
    found_c = hit_lo;
    win_c   = hit_hi ? win_hi : win_lo;
  end

  always_comb begin
    opnd_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == win_c) opnd_c = bin_in[i*W +: W];
    end
  end

  bcd_dabble_step #(.W(W), .DIG(DIG)) u_step (
    .vec (sr_q),
    .nxt (sr_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd_out <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      busy    <= busy_d;
      done    <= done_d;
      done_id <= id_d;
      bcd_out <= bcd_d;
    end
  end

  // Result is captured on the final CONV edge so it is valid during DONE.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    busy_d  = busy;
    done_d  = 1'b0;
    id_d    = done_id;
    bcd_d   = bcd_out;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          gnt[win_c] = 1'b1;
          sr_d       = {BW'(0), opnd_c};
          win_d      = win_c;
          ptr_d      = (win_c == IDW'(N_REQ-1)) ? '0 : win_c + IDW'(1);
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = sr_step[TW-1 -: BW];
          id_d    = win_q;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: reset, single conversions, round robin,
// mid-conversion reset, pending requests and an exhaustive operand sweep.
module tb_bcd_conv_arbiter;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned W     = 8;
  localparam int unsigned DIG   = 3;
  localparam int unsigned IDW   = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic [N_REQ*W-1:0] bin_in;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [DIG*4-1:0] bcd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_conv_arbiter #(.N_REQ(N_REQ), .W(W), .DIG(DIG), .IDW(IDW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .bin_in  (bin_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .bcd_out (bcd_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Runs one conversion for requester r from an IDLE cycle and records what was seen.
  task automatic do_conv(input int r, input logic [7:0] v,
                         output logic [1:0] g, output logic [11:0] bcd,
                         output logic [0:0] id, output int lat, output int bcnt,
                         output logic post_busy, output logic [11:0] held);
    req = '0;
    req[r] = 1'b1;
    bin_in[r*W +: W] = v;
    #1;
    g = gnt;
    step();
    req = '0;
    lat = 0; bcnt = 0; bcd = '0; id = '0;
    for (int j = 1; j <= 30; j++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = j;
        bcd = bcd_out;
        id  = done_id;
        break;
      end
      step();
    end
    step();
    post_busy = busy;
    held = bcd_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; bin_in = '0;
    repeat (3) step();
    checks++; if (gnt !== 2'b00)    begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (done_id !== 1'b0) begin errors++; $display("FAIL reset_done_id: got %b expected 0", done_id); end
    checks++; if (bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h expected 000", bcd_out); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_zero();
    logic [1:0] g; logic [11:0] bcd, held; logic [0:0] id; int lat, bcnt; logic pb;
    do_conv(0, 8'd0, g, bcd, id, lat, bcnt, pb, held);
    checks++; if (g !== 2'b01)    begin errors++; $display("FAIL zero_gnt: got %b expected 01", g); end
    checks++; if (lat !== 9)      begin errors++; $display("FAIL zero_latency: got %0d expected 9", lat); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL zero_bcd: got %h expected 000", bcd); end
    checks++; if (id !== 1'b0)    begin errors++; $display("FAIL zero_id: got %b expected 0", id); end
    checks++; if (pb !== 1'b0)    begin errors++; $display("FAIL zero_busy_after: got %b expected 0", pb); end
  endtask

  task automatic test_req1_values();
    logic [7:0]  vals [3] = '{8'd255, 8'd99, 8'd100};
    logic [11:0] exps [3] = '{12'h255, 12'h099, 12'h100};
    logic [1:0] g; logic [11:0] bcd, held; logic [0:0] id; int lat, bcnt; logic pb;
    for (int k = 0; k < 3; k++) begin
      do_conv(1, vals[k], g, bcd, id, lat, bcnt, pb, held);
      checks++; if (g !== 2'b10)     begin errors++; $display("FAIL req1_gnt[%0d]: got %b expected 10", k, g); end
      checks++; if (bcd !== exps[k]) begin errors++; $display("FAIL req1_bcd[%0d]: got %h expected %h", k, bcd, exps[k]); end
      checks++; if (id !== 1'b1)     begin errors++; $display("FAIL req1_id[%0d]: got %b expected 1", k, id); end
      checks++; if (bcnt !== 9)      begin errors++; $display("FAIL req1_busy_cycles[%0d]: got %0d expected 9", k, bcnt); end
      checks++; if (pb !== 1'b0)     begin errors++; $display("FAIL req1_busy_after[%0d]: got %b expected 0", k, pb); end
      checks++; if (held !== exps[k]) begin errors++; $display("FAIL req1_hold[%0d]: got %h expected %h", k, held, exps[k]); end
    end
  endtask

  task automatic test_rr_alternate();
    logic [1:0]  gexp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [11:0] bexp [4] = '{12'h042, 12'h007, 12'h042, 12'h007};
    int gcount = 0, dcount = 0, prev = 0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    bin_in = {8'd7, 8'd42};
    req = 2'b11;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (gnt !== 2'b00) begin
        if (gcount < 4) begin
          checks++; if (gnt !== gexp[gcount]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", gcount, gnt, gexp[gcount]); end
          checks++; if (c - prev !== ((gcount == 0) ? 0 : 10)) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", gcount, c - prev, (gcount == 0) ? 0 : 10); end
        end
        prev = c;
        gcount++;
      end
      if (done) begin
        if (dcount < 4) begin
          checks++; if (done_id !== gexp[dcount][1]) begin errors++; $display("FAIL rr_done_id[%0d]: got %b expected %b", dcount, done_id, gexp[dcount][1]); end
          checks++; if (bcd_out !== bexp[dcount]) begin errors++; $display("FAIL rr_bcd[%0d]: got %h expected %h", dcount, bcd_out, bexp[dcount]); end
        end
        dcount++;
      end
      step();
    end
    req = '0;
    checks++; if (gcount !== 4) begin errors++; $display("FAIL rr_gnt_count: got %0d expected 4", gcount); end
    checks++; if (dcount !== 4) begin errors++; $display("FAIL rr_done_count: got %0d expected 4", dcount); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [1:0] g; logic [11:0] bcd, held; logic [0:0] id; int lat, bcnt; logic pb;
    int dseen = 0;
    req = 2'b01; bin_in[7:0] = 8'd173;
    #1;
    step();
    req = '0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (bcd_out !== 12'h000) begin errors++; $display("FAIL midrst_bcd: got %h expected 000", bcd_out); end
    checks++; if (done_id !== 1'b0)    begin errors++; $display("FAIL midrst_done_id: got %b expected 0", done_id); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (done) dseen++;
      step();
    end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", dseen); end
    bin_in[15:8] = 8'd5;
    req = 2'b11;
    #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL midrst_ptr: got %b expected 01", gnt); end
    req = '0;
    #1;
    do_conv(0, 8'd173, g, bcd, id, lat, bcnt, pb, held);
    checks++; if (bcd !== 12'h173) begin errors++; $display("FAIL midrst_bcd_redo: got %h expected 173", bcd); end
    checks++; if (lat !== 9)       begin errors++; $display("FAIL midrst_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_pending();
    int bad_gnt = 0, dcyc = 0, lat = 0;
    req = 2'b10; bin_in[15:8] = 8'd50;
    #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL pend_first_gnt: got %b expected 10", gnt); end
    step();
    for (int j = 1; j <= 15; j++) begin
      req = (j == 3) ? 2'b01 : 2'b00;
      #1;
      if (gnt !== 2'b00) bad_gnt++;
      if (done) begin dcyc = j; break; end
      step();
    end
    checks++; if (bad_gnt !== 0) begin errors++; $display("FAIL pend_busy_gnt: got %0d expected 0", bad_gnt); end
    checks++; if (dcyc !== 9)    begin errors++; $display("FAIL pend_done_cycle: got %0d expected 9", dcyc); end
    checks++; if (bcd_out !== 12'h050) begin errors++; $display("FAIL pend_bcd50: got %h expected 050", bcd_out); end
    req = 2'b10; bin_in[15:8] = 8'd77;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL pend_gnt_in_done: got %b expected 00", gnt); end
    step();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL pend_gnt_first_idle: got %b expected 10", gnt); end
    step();
    req = '0;
    for (int j = 1; j <= 30; j++) begin
      if (done) begin lat = j; break; end
      step();
    end
    checks++; if (lat !== 9)           begin errors++; $display("FAIL pend_latency: got %0d expected 9", lat); end
    checks++; if (bcd_out !== 12'h077) begin errors++; $display("FAIL pend_bcd77: got %h expected 077", bcd_out); end
    checks++; if (done_id !== 1'b1)    begin errors++; $display("FAIL pend_id: got %b expected 1", done_id); end
    step();
  endtask

  task automatic test_exhaustive();
    logic [1:0] g; logic [11:0] bcd, held, exp; logic [0:0] id; int lat, bcnt; logic pb;
    int r;
    for (int v = 0; v < 256; v++) begin
      r = int'($urandom_range(0, 1));
      do_conv(r, 8'(v), g, bcd, id, lat, bcnt, pb, held);
      exp = to_bcd(v);
      checks++; if (bcd !== exp) begin errors++; $display("FAIL sweep_bcd[%0d]: got %h expected %h", v, bcd, exp); end
      checks++;
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9) begin
        errors++; $display("FAIL sweep_nibble[%0d]: got %h expected every nibble <= 9", v, bcd);
      end
      checks++; if (id !== 1'(r)) begin errors++; $display("FAIL sweep_id[%0d]: got %b expected %0d", v, id, r); end
      checks++; if (lat !== 9)    begin errors++; $display("FAIL sweep_latency[%0d]: got %0d expected 9", v, lat); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_zero();
    test_req1_values();
    test_rr_alternate();
    test_reset_mid();
    test_pending();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
